// File: rtl/turn_sequencer.sv
// turn_sequencer: counts debounced arrivals at a selected tracker marker pattern.
// A sequence starts on a rising edge of en and ends in DONE when the programmed
// number of arrivals has been seen. If the LEAVE+SEEK phase runs too long, the
// sequence ends in ERR instead. Dropping en returns the block to IDLE from any state.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a rising edge of en
// LEAVE | waiting for the car to leave the starting marker (match=0)
// SEEK  | debouncing marker runs; armed_q low until the current run ends
// DONE  | programmed arrival count reached; held until en drops
// ERR   | timeout expired in LEAVE/SEEK; held until en drops
module turn_sequencer #(
    parameter int              N_SENS  = 3,
    parameter int              CNT_W   = 2,
    parameter int              DEB_CYC = 4,
    parameter int              TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N_SENS-1:0] detect,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  arrivals
);

    localparam int              DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAVE = 3'd1,
        S_SEEK  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  arrivals_q, arrivals_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              match;
    logic              en_rise;
    logic              timed_out;
    logic              finished;
    logic [CNT_W-1:0]  arr_inc;

    // Marker predicate selected by the mode latched at sequence start.
    always_comb begin
        match = 1'b0;
        case (mode_q)
            2'b00:   match = &detect;
            2'b01:   match = detect[N_SENS-1];
            2'b10:   match = detect[0];
            default: match = |detect;
        endcase
    end

    assign en_rise   = en & ~en_prev_q;
    assign timed_out = (tcnt_q == TO_LAST);
    assign arr_inc   = (arrivals_q == CNT_MAX) ? arrivals_q : arrivals_q + CNT_W'(1);

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d    = state_q;
        en_prev_d  = en;
        mode_d     = mode_q;
        count_d    = count_q;
        arrivals_d = arrivals_q;
        deb_d      = deb_q;
        tcnt_d     = tcnt_q;
        armed_d    = armed_q;
        finished   = 1'b0;

        if (!en) begin
            state_d    = S_IDLE;
            arrivals_d = '0;
            deb_d      = '0;
            tcnt_d     = '0;
            armed_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_rise) begin
                        state_d    = S_LEAVE;
                        mode_d     = mode;
                        count_d    = count;
                        arrivals_d = '0;
                        deb_d      = '0;
                        tcnt_d     = '0;
                        armed_d    = 1'b0;
                    end
                end
                S_LEAVE: begin
                    tcnt_d = tcnt_q + TO_W'(1);
                    // A zero count completes as soon as the starting marker is left.
                    if (!match && (count_q == '0)) begin
                        finished = 1'b1;
                    end
                    if (finished) begin
                        state_d = S_DONE;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                    end else if (!match) begin
                        state_d = S_SEEK;
                        armed_d = 1'b1;
                        deb_d   = '0;
                    end
                end
                S_SEEK: begin
                    tcnt_d = tcnt_q + TO_W'(1);
                    if (!match) begin
                        deb_d   = '0;
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        if (deb_q == DEB_LAST) begin
                            // One arrival per contiguous run; disarm until the run ends.
                            arrivals_d = arr_inc;
                            armed_d    = 1'b0;
                            deb_d      = '0;
                            if (arr_inc == count_q) begin
                                finished = 1'b1;
                            end
                        end else begin
                            deb_d = deb_q + DEB_W'(1);
                        end
                    end
                    // The final arrival takes priority over a coincident timeout.
                    if (finished) begin
                        state_d = S_DONE;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d    = S_IDLE;
                    arrivals_d = '0;
                end
            endcase
        end

        busy_d  = (state_d == S_LEAVE) || (state_d == S_SEEK);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            en_prev_q  <= 1'b0;
            mode_q     <= 2'b00;
            count_q    <= '0;
            arrivals_q <= '0;
            deb_q      <= '0;
            tcnt_q     <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_prev_q  <= en_prev_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            arrivals_q <= arrivals_d;
            deb_q      <= deb_d;
            tcnt_q     <= tcnt_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign arrivals = arrivals_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: stimulus pushes the expected output tuple
// {busy,done,error,arrivals} and the cycle it must appear in; the monitor pops
// and compares each time the output tuple changes.
module tb_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en;
    logic [1:0] mode;
    logic [2:0] detect;
    logic [1:0] count;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] arrivals;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    int         exp_cyc[$];
    logic [4:0] exp_val[$];
    string      exp_tag[$];

    turn_sequencer #(
        .N_SENS (3),
        .CNT_W  (2),
        .DEB_CYC(4),
        .TO_W   (24),
        .TIMEOUT(24'd50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .detect  (detect),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .arrivals(arrivals)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] tup(input logic b, input logic d, input logic e, input logic [1:0] a);
        return {b, d, e, a};
    endfunction

    task automatic expect_at(input string tag, input int c, input logic [4:0] v);
        exp_tag.push_back(tag);
        exp_cyc.push_back(c);
        exp_val.push_back(v);
    endtask

    task automatic expect_now(input string tag, input logic [4:0] v);
        expect_at(tag, cyc, v);
    endtask

    task automatic apply(input logic e, input logic [2:0] d);
        en     = e;
        detect = d;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic e, input logic [2:0] d, input int n);
        repeat (n) apply(e, d);
    endtask

    task automatic monitor_loop();
        logic [4:0] prev;
        logic [4:0] cur;
        logic [4:0] ev;
        int         ec;
        string      et;
        prev = 5'b0;
        forever begin
            @(negedge clk);
            cur = {busy, done, error, arrivals};
            if (cur !== prev) begin
                checks++;
                if (exp_val.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%b at cycle %0d", cur, cyc);
                end else begin
                    ev = exp_val.pop_front();
                    ec = exp_cyc.pop_front();
                    et = exp_tag.pop_front();
                    if (cur !== ev || cyc != ec) begin
                        errors++;
                        $display("FAIL %s got=%b@%0d want=%b@%0d", et, cur, cyc, ev, ec);
                    end
                end
                prev = cur;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        en     = 1'b0;
        detect = 3'b000;
        mode   = 2'b00;
        count  = 2'd0;
        fork
            monitor_loop();
        join_none

        #2 rst = 1'b1;
        #10 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, arrivals} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", {busy, done, error, arrivals}, 5'b0);
        end
        hold(1'b0, 3'b000, 2);

        // 1: crossing, count 2, start on the marker
        mode = 2'b00; count = 2'd2;
        apply(1'b1, 3'b111); expect_now("t1_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b111);
        hold(1'b1, 3'b000, 2);
        hold(1'b1, 3'b111, 4); expect_now("t1_arr1", tup(1, 0, 0, 2'd1));
        hold(1'b1, 3'b111, 2);
        hold(1'b1, 3'b000, 2);
        hold(1'b1, 3'b111, 4); expect_now("t1_done", tup(0, 1, 0, 2'd2));
        hold(1'b1, 3'b111, 2);
        apply(1'b0, 3'b000); expect_now("t1_idle", tup(0, 0, 0, 2'd0));

        // 2: short glitch ignored
        mode = 2'b00; count = 2'd1;
        apply(1'b1, 3'b000); expect_now("t2_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b111, 3);
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b111, 4); expect_now("t2_done", tup(0, 1, 0, 2'd1));
        apply(1'b0, 3'b000); expect_now("t2_idle", tup(0, 0, 0, 2'd0));

        // 3a: left marker counted
        mode = 2'b01; count = 2'd1;
        apply(1'b1, 3'b000); expect_now("t3a_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b100, 4); expect_now("t3a_done", tup(0, 1, 0, 2'd1));
        apply(1'b1, 3'b100);
        apply(1'b0, 3'b000); expect_now("t3a_idle", tup(0, 0, 0, 2'd0));

        // 3b: right sensor ignored in left mode
        mode = 2'b01; count = 2'd1;
        apply(1'b1, 3'b000); expect_now("t3b_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b001, 5);
        apply(1'b0, 3'b000); expect_now("t3b_abort", tup(0, 0, 0, 2'd0));

        // 3c: right mode counts it
        mode = 2'b10; count = 2'd1;
        apply(1'b1, 3'b000); expect_now("t3c_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b001, 4); expect_now("t3c_done", tup(0, 1, 0, 2'd1));
        apply(1'b0, 3'b000); expect_now("t3c_idle", tup(0, 0, 0, 2'd0));

        // 4: timeout with one of three arrivals
        mode = 2'b00; count = 2'd3;
        apply(1'b1, 3'b000); c0 = cyc; expect_now("t4_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b111, 4); expect_now("t4_arr1", tup(1, 0, 0, 2'd1));
        expect_at("t4_error", c0 + 50, tup(0, 0, 1, 2'd1));
        while (cyc < c0 + 53) apply(1'b1, 3'b000);
        apply(1'b0, 3'b000); expect_now("t4_idle", tup(0, 0, 0, 2'd0));

        // 5a: abort mid-SEEK
        mode = 2'b00; count = 2'd2;
        apply(1'b1, 3'b000); expect_now("t5a_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        hold(1'b1, 3'b111, 4); expect_now("t5a_arr1", tup(1, 0, 0, 2'd1));
        apply(1'b1, 3'b000);
        apply(1'b0, 3'b000); expect_now("t5a_abort", tup(0, 0, 0, 2'd0));

        // 5b: asynchronous reset mid-LEAVE
        apply(1'b1, 3'b111); expect_now("t5b_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b111);
        en = 1'b0;
        expect_now("t5b_rst", tup(0, 0, 0, 2'd0));
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, arrivals} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", {busy, done, error, arrivals}, 5'b0);
        end
        #1 rst = 1'b0;
        hold(1'b0, 3'b000, 2);

        // 6a: zero count
        mode = 2'b00; count = 2'd0;
        apply(1'b1, 3'b000); expect_now("t6a_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000); expect_now("t6a_done", tup(0, 1, 0, 2'd0));
        apply(1'b0, 3'b000); expect_now("t6a_idle", tup(0, 0, 0, 2'd0));

        // 6b: count change during SEEK ignored
        mode = 2'b00; count = 2'd1;
        apply(1'b1, 3'b000); expect_now("t6b_leave", tup(1, 0, 0, 2'd0));
        apply(1'b1, 3'b000);
        count = 2'd3; mode = 2'b11;
        hold(1'b1, 3'b111, 4); expect_now("t6b_done", tup(0, 1, 0, 2'd1));
        apply(1'b0, 3'b000); expect_now("t6b_idle", tup(0, 0, 0, 2'd0));

        for (int i = 0; i < 10 && exp_val.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_val.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got=%0d want=0 next=%s", exp_val.size(), exp_tag[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
